fp8_mul_sched: RTL and testbench
================================

# fp8_mul_sched

Round-robin scheduler that shares one serial-nibble FP8 (E4M3) multiplier between two requesters. Each requester hands over a full operand pair (a, b) with a valid/ready handshake. The scheduler resets the multiplier, streams the four operand nibbles into it, and waits a fixed number of cycles, because the multiplier has no done flag. It then captures the 8-bit product and returns it, tagged with the requester id, on a single response channel with backpressure. The block sits between the chip-level I/O sequencing logic and the multiplier's io_in/io_out pins.

## Interface
- WAIT_CYCLES, default 24: cycles spent in WAIT after the last nibble before the result is sampled; legal range 1..63.
- clock  in  1  single clock; all logic on its rising edge
- reset  in  1  synchronous, active-high
- req0_valid  in  1  requester 0 has an operand pair
- req0_a, req0_b  in  8 each  requester 0 operands (E4M3)
- req0_ready  out  1  requester 0 operands accepted this cycle
- req1_valid, req1_a, req1_b, req1_ready  same as requester 0, for requester 1
- mul_reset  out  1  drives the multiplier's reset bit
- mul_enable  out  1  drives the multiplier's enable bit
- mul_data  out  4  drives the multiplier's data nibble
- mul_result  in  8  the multiplier's output byte
- resp_valid  out  1  response available
- resp_id  out  1  requester that owns the response
- resp_data  out  8  captured product
- resp_ready  in  1  consumer accepts the response

## Operation
- States: IDLE, MRST, FEED, WAIT, RESP.
- IDLE, grant rule:
  - If exactly one reqN_valid is high, grant that requester.
  - If both are high, grant the one selected by the `prio` bit.
  - reqN_ready is high combinationally only in IDLE, only for the granted requester, and only while its valid is high.
  - On the handshake: latch a, b and id; set `prio` to the other requester; go to MRST.
  - A requester must hold valid until it sees ready.
- MRST: mul_reset = 1 for exactly one cycle. Go to FEED with nibble index 0.
- FEED: mul_enable = 1 for four consecutive cycles.
  - mul_data in order: a[7:4], a[3:0], b[7:4], b[3:0].
  - After the 4th nibble, go to WAIT with the counter loaded to WAIT_CYCLES-1.
- WAIT: mul_enable = 0 and mul_data = 0.
  - Decrement the counter each cycle.
  - In the cycle the counter reads 0: resp_data <= mul_result, resp_id <= latched id; go to RESP.
- RESP: resp_valid = 1. Hold resp_data and resp_id stable until resp_valid && resp_ready, then go to IDLE.
  - The next grant occurs no earlier than the cycle after IDLE is entered.
- mul_reset = reset OR (state == MRST), so the multiplier is also reset whenever the scheduler is.
- `prio` toggles only on a grant. A lone requester may be granted repeatedly.
- resp_data is passed through unmodified. The scheduler does not interpret FP8 values; NaN, infinity and denormal results are the multiplier's responsibility.

## Timing
- Reset values (on the cycle after reset is high):
  - state IDLE, prio = 0, counter = 0.
  - req0_ready = req1_ready = 0, mul_enable = 0, mul_data = 0.
  - resp_valid = 0, resp_id = 0, resp_data = 0.
- Accept in cycle T (IDLE):
  - T+1: MRST, mul_reset = 1.
  - T+2..T+5: FEED, mul_enable = 1.
  - T+6..T+5+WAIT_CYCLES: WAIT; mul_result is sampled at T+5+WAIT_CYCLES.
  - T+6+WAIT_CYCLES: resp_valid first high.
- Latency from accept to resp_valid = WAIT_CYCLES + 6.
- Minimum issue interval with resp_ready tied high = WAIT_CYCLES + 8.
- Reset asserted in any state: return to IDLE at the next edge and drop any in-flight operation; no response is produced for it.
- Valid rising in any state other than IDLE: ready stays low. The request is served at the next IDLE and is not lost.
- resp_ready low: the block stalls in RESP indefinitely, and both reqN_ready stay low.

## Test plan
- Single request, WAIT_CYCLES = 24:
  - Stimulus: req0 a = 0x38, b = 0x40. A stub multiplier drives mul_result = 0x5A from the 2nd WAIT cycle.
  - Required: req0_ready high in the accept cycle; mul_reset pulse one cycle later; mul_data 3, 8, 4, 0 with mul_enable high; resp_valid at accept+30 with resp_id 0 and resp_data 0x5A.
- Both valid out of reset:
  - Required: req0 granted first (prio = 0), then req1.
  - Resp_id order: 0, 1, 0, 1 while both stay valid with resp_ready = 1.
- Only req1 valid for three transactions: three consecutive grants to req1 and resp_id 1, 1, 1; prio ends at 0.
- Backpressure: hold resp_ready = 0 for 10 cycles in RESP.
  - Required: resp_data and resp_id stable, and no req_ready during the stall.
  - Completion one cycle after resp_ready rises; IDLE on the following cycle.
- Reset during FEED (after the 2nd nibble):
  - Required: next cycle all outputs at reset values and mul_reset = 1 during reset; no resp_valid ever appears for that request.
- Sampling point: the stub changes mul_result from 0x11 to 0x22 exactly one cycle after the last WAIT cycle. Required: resp_data = 0x11.

Source files
------------

// File: rtl/fp8_mul_sched.sv
// Round-robin scheduler sharing one serial-nibble E4M3 multiplier between two
// requesters; fixed-latency result capture with a backpressured response port.
module fp8_mul_sched #(
  parameter int unsigned WAIT_CYCLES = 24
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  output logic       req1_ready,
  output logic       mul_reset,
  output logic       mul_enable,
  output logic [3:0] mul_data,
  input  logic [7:0] mul_result,
  output logic       resp_valid,
  output logic       resp_id,
  output logic [7:0] resp_data,
  input  logic       resp_ready
);

  typedef enum logic [2:0] {IDLE, MRST, FEED, WAIT, RESP} state_t;

  state_t     state_q, state_d;
  logic       prio_q, prio_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic       id_q, id_d;
  logic [1:0] nib_q, nib_d;
  logic [5:0] cnt_q, cnt_d;
  logic [7:0] rdata_q, rdata_d;
  logic       rid_q, rid_d;
  logic       hold_q, hold_d;
  logic       pick1;
  logic       grant;

  assign pick1      = req1_valid && (!req0_valid || prio_q);
  assign mul_reset  = reset || (state_q == MRST);
  assign resp_data  = rdata_q;
  assign resp_id    = rid_q;

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    a_d        = a_q;
    b_d        = b_q;
    id_d       = id_q;
    nib_d      = nib_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    rid_d      = rid_q;
    hold_d     = (state_q == RESP) && resp_ready;
    grant      = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    mul_enable = 1'b0;
    mul_data   = '0;
    resp_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        // First IDLE cycle after a response is a dead cycle: no grant yet.
        if (!hold_q) begin
          req0_ready = req0_valid && !pick1;
          req1_ready = req1_valid && pick1;
          grant      = req0_valid || req1_valid;
          if (grant) begin
            a_d     = pick1 ? req1_a : req0_a;
            b_d     = pick1 ? req1_b : req0_b;
            id_d    = pick1;
            prio_d  = !pick1;
            state_d = MRST;
          end
        end
      end
      MRST: begin
        nib_d   = '0;
        state_d = FEED;
      end
      FEED: begin
        mul_enable = 1'b1;
        unique case (nib_q)
          2'd0: mul_data = a_q[7:4];
          2'd1: mul_data = a_q[3:0];
          2'd2: mul_data = b_q[7:4];
          default: mul_data = b_q[3:0];
        endcase
        nib_d = nib_q + 2'd1;
        if (nib_q == 2'd3) begin
          cnt_d   = 6'(WAIT_CYCLES - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rdata_d = mul_result;
          rid_d   = id_q;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= 1'b0;
      nib_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      rid_q   <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      a_q     <= a_d;
      b_q     <= b_d;
      id_q    <= id_d;
      nib_q   <= nib_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      rid_q   <= rid_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: tb/tb_fp8_mul_sched.sv
// Directed bench for fp8_mul_sched with a stub multiplier driven from the bench.
module tb_fp8_mul_sched;

  logic       clock = 1'b0;
  logic       reset;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic       req0_ready, req1_ready;
  logic       mul_reset, mul_enable;
  logic [3:0] mul_data;
  logic [7:0] mul_result;
  logic       resp_valid, resp_id, resp_ready;
  logic [7:0] resp_data;

  int checks = 0;
  int errors = 0;

  int         g_cyc[8];
  logic       g_who[8];
  int         r_cyc[8];
  logic       r_id[8];
  logic [7:0] r_data[8];
  int         ng, nr;
  bit         tmo;

  always #5 clock = ~clock;

  fp8_mul_sched #(.WAIT_CYCLES(24)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .mul_reset(mul_reset), .mul_enable(mul_enable), .mul_data(mul_data),
    .mul_result(mul_result),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
    .resp_ready(resp_ready)
  );

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Holds the given valids until n responses are seen, logging grants and responses.
  task automatic run_stream(input logic v0, input logic v1, input int n);
    int cyc;
    ng = 0; nr = 0; tmo = 0; cyc = 0;
    @(negedge clock);
    req0_valid = v0; req1_valid = v1; resp_ready = 1'b1;
    while (nr < n && cyc < 400) begin
      #1;
      if ((req0_ready || req1_ready) && ng < 8) begin
        g_who[ng] = req1_ready; g_cyc[ng] = cyc; ng++;
      end
      if (resp_valid && nr < 8) begin
        r_id[nr] = resp_id; r_cyc[nr] = cyc; r_data[nr] = resp_data; nr++;
      end
      @(negedge clock);
      cyc++;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    if (nr < n) tmo = 1;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (mul_reset !== 1'b1) begin
      errors++; $display("FAIL reset_mul_reset: got %b expected 1", mul_reset);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({req0_ready, req1_ready, mul_enable, mul_data, resp_valid, resp_id, resp_data, mul_reset}
        !== 18'd0) begin
      errors++;
      $display("FAIL reset_values: got rdy=%b%b en=%b data=%h rv=%b id=%b rd=%h mrst=%b expected all 0",
               req0_ready, req1_ready, mul_enable, mul_data, resp_valid, resp_id, resp_data, mul_reset);
    end
  endtask

  task automatic test_single();
    logic [3:0] exp_nib[4];
    bit early;
    exp_nib = '{4'h3, 4'h8, 4'h4, 4'h0};
    early = 0;
    apply_reset();
    mul_result = 8'h00; resp_ready = 1'b1;
    req0_a = 8'h38; req0_b = 8'h40; req0_valid = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL single_accept: got rdy0=%b rdy1=%b expected 1 0", req0_ready, req1_ready);
    end
    for (int k = 1; k <= 30; k++) begin
      @(negedge clock);
      if (k == 1) req0_valid = 1'b0;
      if (k == 7) mul_result = 8'h5A;
      #1;
      if (k == 1) begin
        checks++;
        if (mul_reset !== 1'b1 || mul_enable !== 1'b0) begin
          errors++; $display("FAIL single_mrst: got mrst=%b en=%b expected 1 0", mul_reset, mul_enable);
        end
      end else if (k >= 2 && k <= 5) begin
        checks++;
        if (mul_enable !== 1'b1 || mul_data !== exp_nib[k-2] || mul_reset !== 1'b0) begin
          errors++;
          $display("FAIL single_nibble%0d: got en=%b data=%h mrst=%b expected 1 %h 0",
                   k - 2, mul_enable, mul_data, mul_reset, exp_nib[k-2]);
        end
      end else if (k == 6) begin
        checks++;
        if (mul_enable !== 1'b0 || mul_data !== 4'h0) begin
          errors++; $display("FAIL single_wait_idle_bus: got en=%b data=%h expected 0 0", mul_enable, mul_data);
        end
      end
      if (k < 30 && resp_valid) early = 1;
      if (k == 30) begin
        checks++;
        if (early) begin
          errors++; $display("FAIL single_early_resp: got resp_valid before accept+30 expected none");
        end
        checks++;
        if (resp_valid !== 1'b1 || resp_id !== 1'b0 || resp_data !== 8'h5A) begin
          errors++;
          $display("FAIL single_resp: got rv=%b id=%b data=%h expected 1 0 5a", resp_valid, resp_id, resp_data);
        end
      end
    end
  endtask

  task automatic test_both_valid();
    apply_reset();
    mul_result = 8'h3C;
    req0_a = 8'h11; req0_b = 8'h22; req1_a = 8'h33; req1_b = 8'h44;
    run_stream(1'b1, 1'b1, 4);
    checks++;
    if (tmo || ng < 4) begin
      errors++; $display("FAIL both_timeout: got %0d grants %0d resps expected 4 4", ng, nr);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (g_who[i] !== 1'(i % 2) || r_id[i] !== 1'(i % 2)) begin
          errors++;
          $display("FAIL both_order%0d: got grant=%b id=%b expected %0d", i, g_who[i], r_id[i], i % 2);
        end
      end
      checks++;
      if (r_cyc[0] - g_cyc[0] != 30 || r_data[0] !== 8'h3C) begin
        errors++;
        $display("FAIL both_latency: got %0d data=%h expected 30 3c", r_cyc[0] - g_cyc[0], r_data[0]);
      end
      checks++;
      if (g_cyc[1] - g_cyc[0] != 32) begin
        errors++; $display("FAIL both_interval: got %0d expected 32", g_cyc[1] - g_cyc[0]);
      end
    end
  endtask

  task automatic test_lone_req1();
    run_stream(1'b0, 1'b1, 3);
    checks++;
    if (tmo || ng < 3) begin
      errors++; $display("FAIL lone_timeout: got %0d grants %0d resps expected 3 3", ng, nr);
    end else begin
      checks++;
      if ({g_who[0], g_who[1], g_who[2], r_id[0], r_id[1], r_id[2]} !== 6'b111111) begin
        errors++;
        $display("FAIL lone_ids: got grants %b%b%b ids %b%b%b expected 111 111",
                 g_who[0], g_who[1], g_who[2], r_id[0], r_id[1], r_id[2]);
      end
    end
    run_stream(1'b1, 1'b1, 1);
    checks++;
    if (tmo || ng < 1 || g_who[0] !== 1'b0) begin
      errors++; $display("FAIL lone_prio_after: got grant=%b (n=%0d) expected 0", g_who[0], ng);
    end
  endtask

  task automatic test_backpressure();
    int   w;
    bit   bad;
    apply_reset();
    mul_result = 8'h77; resp_ready = 1'b0;
    req0_a = 8'h01; req0_b = 8'h02; req0_valid = 1'b1;
    @(negedge clock);
    req0_valid = 1'b0;
    w = 0;
    while (!resp_valid && w < 100) begin
      @(negedge clock); w++;
    end
    checks++;
    if (!resp_valid) begin
      errors++; $display("FAIL bp_timeout: got no resp_valid expected one within 100 cycles");
    end
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      if (k == 2) begin req0_valid = 1'b1; req1_valid = 1'b1; mul_result = 8'h99; end
      #1;
      if (resp_valid !== 1'b1 || resp_data !== 8'h77 || resp_id !== 1'b0 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0) bad = 1;
      @(negedge clock);
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL bp_stall: got rv=%b data=%h id=%b rdy=%b%b expected stable 1 77 0 with ready 00",
               resp_valid, resp_data, resp_id, req0_ready, req1_ready);
    end
    resp_ready = 1'b1;
    #1;
    checks++;
    if (resp_valid !== 1'b1) begin
      errors++; $display("FAIL bp_release: got rv=%b expected 1", resp_valid);
    end
    @(negedge clock); #1;
    checks++;
    if (resp_valid !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL bp_idle: got rv=%b rdy=%b%b expected 0 00", resp_valid, req0_ready, req1_ready);
    end
    @(negedge clock); #1;
    checks++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      errors++; $display("FAIL bp_pending_grant: got rdy0=%b rdy1=%b expected 0 1", req0_ready, req1_ready);
    end
    @(negedge clock);
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_reset_in_feed();
    bit seen;
    apply_reset();
    resp_ready = 1'b1; mul_result = 8'h55;
    req0_a = 8'hA6; req0_b = 8'h3B; req0_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      if (k == 1) req0_valid = 1'b0;
    end
    #1;
    checks++;
    if (mul_enable !== 1'b1 || mul_data !== 4'h6) begin
      errors++; $display("FAIL feed_second_nibble: got en=%b data=%h expected 1 6", mul_enable, mul_data);
    end
    reset = 1'b1;
    @(negedge clock); #1;
    checks++;
    if ({mul_reset, mul_enable, mul_data, resp_valid, req0_ready, req1_ready, resp_data} !== 17'h10000) begin
      errors++;
      $display("FAIL feed_reset_values: got mrst=%b en=%b data=%h rv=%b rdy=%b%b rd=%h expected 1 0 0 0 00 00",
               mul_reset, mul_enable, mul_data, resp_valid, req0_ready, req1_ready, resp_data);
    end
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clock); #1;
      if (resp_valid || mul_enable) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL feed_reset_dropped: got activity after reset expected none");
    end
  endtask

  task automatic test_sampling_point();
    apply_reset();
    resp_ready = 1'b0; mul_result = 8'h11;
    req0_a = 8'h44; req0_b = 8'h48; req0_valid = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clock);
      if (k == 1) req0_valid = 1'b0;
    end
    mul_result = 8'h22;
    #1;
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== 8'h11) begin
      errors++; $display("FAIL sample_point: got rv=%b data=%h expected 1 11", resp_valid, resp_data);
    end
    @(negedge clock); #1;
    checks++;
    if (resp_data !== 8'h11) begin
      errors++; $display("FAIL sample_hold: got data=%h expected 11", resp_data);
    end
    resp_ready = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    mul_result = '0; resp_ready = 1'b1;
    test_reset();
    test_single();
    test_both_valid();
    test_lone_req1();
    test_backpressure();
    test_reset_in_feed();
    test_sampling_point();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
